// File: rtl/dcdc_sync_gen.sv
// Multi-channel phase-staggered sync generator for switching regulators.
// Period, high time and per-channel phase are shadowed and applied only at period wraps.
module dcdc_sync_gen #(
  parameter int NCH = 4,
  parameter int DW  = 8
) (
  input  logic              dspclk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [DW-1:0]     div,
  input  logic [DW-1:0]     high,
  input  logic [NCH*DW-1:0] phase,
  input  logic              update,
  output logic              update_ack,
  output logic              running,
  output logic              tick,
  output logic [NCH-1:0]    sync
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t         state;
  logic [DW-1:0]  cnt;
  logic [DW-1:0]  div_a;
  logic [DW-1:0]  high_a;
  logic [DW-1:0]  phase_a [NCH];
  logic           pending;

  logic [DW-1:0]  div_c;
  logic [DW-1:0]  phase_c [NCH];
  logic           wrap;
  logic           req;
  logic           load;
  logic [DW:0]    d;
  logic [NCH-1:0] sync_c;

  // Clamped view of the shadow inputs, ready to be loaded into the active set
  always_comb begin
    div_c = (div == '0) ? DW'(1) : div;
    for (int unsigned k = 0; k < NCH; k++) begin
      phase_c[k] = (phase[k*DW +: DW] > div_c) ? div_c : phase[k*DW +: DW];
    end
  end

  assign wrap = (cnt == div_a);
  assign req  = pending | update;
  assign load = (state == IDLE) ? enable : (wrap & req);

  // Phase distance modulo the period, kept in DW+1 bits so div_a+1 cannot overflow
  always_comb begin
    sync_c = '0;
    d      = '0;
    for (int unsigned k = 0; k < NCH; k++) begin
      if (cnt >= phase_a[k]) begin
        d = {1'b0, cnt} - {1'b0, phase_a[k]};
      end else begin
        d = {1'b0, cnt} + {1'b0, div_a} + (DW+1)'(1) - {1'b0, phase_a[k]};
      end
      sync_c[k] = running & (d < {1'b0, high_a});
    end
  end

  always_ff @(posedge dspclk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      running    <= 1'b0;
      tick       <= 1'b0;
      update_ack <= 1'b0;
      sync       <= '0;
      cnt        <= '0;
      pending    <= 1'b0;
      div_a      <= DW'(1);
      high_a     <= '0;
      for (int unsigned k = 0; k < NCH; k++) begin
        phase_a[k] <= '0;
      end
    end else begin
      tick       <= 1'b0;
      update_ack <= 1'b0;
      sync       <= sync_c;
      if (load) begin
        div_a      <= div_c;
        high_a     <= high;
        update_ack <= req;
        for (int unsigned k = 0; k < NCH; k++) begin
          phase_a[k] <= phase_c[k];
        end
      end
      unique case (state)
        IDLE: begin
          if (enable) begin
            state   <= RUN;
            running <= 1'b1;
            cnt     <= '0;
            pending <= 1'b0;
          end else if (update) begin
            pending <= 1'b1;
          end
        end
        RUN: begin
          // enable is only looked at on the wrap, so the period in progress always completes
          if (wrap) begin
            cnt     <= '0;
            tick    <= 1'b1;
            pending <= 1'b0;
            if (!enable) begin
              state   <= IDLE;
              running <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
            if (update) pending <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/dcdc_sync_gen.md
# dcdc_sync_gen

Multi-channel, parametrised sync-clock generator for switching regulators (MAX1820-class and similar) in the DSP clock domain. It derives NCH phase-staggered sync outputs from dspclk with a programmable period, high time and per-channel phase. Configuration changes are applied glitch-free at period boundaries. Enable and disable are clean, with no runt pulses. It sits between the register-bank control fields and the regulator SYNC pins, replacing the fixed-divide, single-output generator.

## Interface
- NCH, 4: number of sync output channels (1..16)
- DW, 8: divider/counter width; period = div+1 dspclk cycles, up to 2^DW
- dspclk  in  1  sole clock; all logic is posedge dspclk
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  run request, level-sensitive
- div  in  DW  period minus one (shadow input)
- high  in  DW  high time in cycles (shadow input)
- phase  in  NCH*DW  per-channel phase offset, channel k in bits [k*DW +: DW] (shadow input)
- update  in  1  single-cycle request to apply the shadow inputs at the next wrap
- update_ack  out  1  one-cycle pulse when the shadow inputs are loaded into the active set
- running  out  1  generator active
- tick  out  1  one-cycle pulse on each period wrap
- sync  out  NCH  registered sync outputs

## Operation
- Active set: div_a, high_a, phase_a[k]; internal state: cnt (DW bits), pending.
- Clamps applied when loading:
  - div_a = max(div, 1), giving a minimum period of 2.
  - phase_a[k] = min(phase[k], div_a).
  - high is not clamped.
- States:
  - IDLE: running=0, cnt=0.
  - RUN.
- IDLE -> RUN when enable=1 is sampled. On that edge:
  - The active set loads from the inputs.
  - cnt<=0 and running<=1.
  - pending<=0; update_ack pulses if pending or update was 1.
- RUN, cnt<div_a: cnt<=cnt+1.
- RUN, cnt==div_a (wrap):
  - cnt<=0 and tick<=1.
  - If pending or update is 1: load the active set, clear pending, pulse update_ack.
  - If enable=0: go to IDLE (running<=0). The period in progress always completes.
- update=1 outside a wrap sets pending. Additional update pulses before the wrap coalesce into one.
- Channel k phase distance: d_k = (cnt - phase_a[k]) mod (div_a+1), computed in DW+1 bits with no wraparound error.
- sync[k] <= running & (d_k < high_a), evaluated from the current cnt.
  - high_a=0: sync[k] is held low.
  - high_a>div_a: sync[k] is held high while running.
- Deasserting and then reasserting enable before the wrap leaves the generator running uninterrupted, with no restart.
- Active config never changes mid-period, so no output glitches or runt pulses occur.

## Timing
- Reset values: running=0, tick=0, update_ack=0, sync=0, cnt=0, pending=0, active set = {div_a=1, high_a=0, phase_a=0}.
- Enable latency: enable sampled high at edge E gives running=1 after E. sync reflects cnt=0 after edge E+1 (one-cycle registered lag).
- sync[k] lags cnt by exactly one cycle.
- tick and update_ack are asserted during the cycle following the wrap edge, aligned with cnt=0.
- Stop: after the wrap edge with enable=0, running=0. The final sync value (for cnt=div_a) is held one more cycle, then sync=0.
- update arriving in the same cycle as the wrap is applied at that wrap.
- update during IDLE sets pending, which is then consumed at start.
- rst_n low at any time: all outputs go to reset values immediately. Release is synchronous to the next dspclk edge.

## Test plan
- Staggered channels: DW=8, NCH=4, div=9, high=5, phases {0,2,5,9}, enable=1. Required response:
  - sync0 high for cnt 0-4.
  - sync1 high for cnt 2-6.
  - sync2 high for cnt 5-9.
  - sync3 high for cnt 9,0-3.
  - Period 10; tick every 10 cycles.
- Update at boundary: while running div=9, set div=4, high=2 and pulse update at cnt=3. Required response:
  - The current period completes with 10 cycles.
  - update_ack pulses with cnt=0.
  - The next period is 5 cycles and sync0 is high for 2 cycles.
  - Repeat with update asserted exactly at cnt=9: the new config applies at that wrap.
- Clean stop: drop enable at cnt=4. Required response:
  - The period runs to cnt=9.
  - running falls after the wrap.
  - sync goes to 0 one cycle later, with no truncated high pulse.
  - Re-raising enable at cnt=7 instead leaves running unbroken.
- Edge clamps:
  - high=0: all sync low.
  - high=200 with div=9: all sync constantly high while running.
  - div=0: period 2.
  - phase=50 with div=9: behaves as phase 9.
- Reset mid-operation: assert rst_n=0 at cnt=6 with sync high. Required response:
  - All outputs drop immediately.
  - After release with enable=1, restart from cnt=0 with the currently presented inputs.
- Coalesced update: pulse update three times within one period. Exactly one update_ack occurs, and the last-presented values are loaded.
